// File: rtl/ui_pkg.sv
// Shared screen geometry, glyph size, character codes, colours and renderer states
// for the 160x120 text renderer.
package ui_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int GLYPH_W  = 5;
  localparam int GLYPH_H  = 7;

  localparam logic [5:0] CH_SPACE = 6'd0;
  localparam logic [5:0] CH_A     = 6'd1;
  localparam logic [5:0] CH_0     = 6'd27;
  localparam logic [5:0] CH_BANG  = 6'd37;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_DRAW = 3'd2,
    ST_NEXT = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5
  } rstate_e;

endpackage

// File: rtl/glyph_rom_5x7.sv
// Combinational 5x7 font: one glyph row per lookup, bit 4 is the leftmost column.
// Codes outside the defined set (and code 0) render as blank space.
module glyph_rom_5x7
  import ui_pkg::*;
(
  input  logic [5:0] code_i,
  input  logic [2:0] row_i,
  output logic [4:0] bits_o
);

  // Rows 0..6 packed top to bottom, row 0 in bits [34:30].
  logic [34:0] glyph;

  always_comb begin
    glyph = '0;
    case (code_i)
      6'd1:    glyph = 35'b01110_10001_10001_11111_10001_10001_10001; // A
      6'd2:    glyph = 35'b11110_10001_10001_11110_10001_10001_11110; // B
      6'd3:    glyph = 35'b01110_10001_10000_10000_10000_10001_01110; // C
      6'd4:    glyph = 35'b11110_10001_10001_10001_10001_10001_11110; // D
      6'd5:    glyph = 35'b11111_10000_10000_11110_10000_10000_11111; // E
      6'd6:    glyph = 35'b11111_10000_10000_11110_10000_10000_10000; // F
      6'd7:    glyph = 35'b01110_10001_10000_10111_10001_10001_01111; // G
      6'd8:    glyph = 35'b10001_10001_10001_11111_10001_10001_10001; // H
      6'd9:    glyph = 35'b01110_00100_00100_00100_00100_00100_01110; // I
      6'd10:   glyph = 35'b00111_00010_00010_00010_00010_10010_01100; // J
      6'd11:   glyph = 35'b10001_10010_10100_11000_10100_10010_10001; // K
      6'd12:   glyph = 35'b10000_10000_10000_10000_10000_10000_11111; // L
      6'd13:   glyph = 35'b10001_11011_10101_10101_10001_10001_10001; // M
      6'd14:   glyph = 35'b10001_10001_11001_10101_10011_10001_10001; // N
      6'd15:   glyph = 35'b01110_10001_10001_10001_10001_10001_01110; // O
      6'd16:   glyph = 35'b11110_10001_10001_11110_10000_10000_10000; // P
      6'd17:   glyph = 35'b01110_10001_10001_10001_10101_10010_01101; // Q
      6'd18:   glyph = 35'b11110_10001_10001_11110_10100_10010_10001; // R
      6'd19:   glyph = 35'b01111_10000_10000_01110_00001_00001_11110; // S
      6'd20:   glyph = 35'b11111_00100_00100_00100_00100_00100_00100; // T
      6'd21:   glyph = 35'b10001_10001_10001_10001_10001_10001_01110; // U
      6'd22:   glyph = 35'b10001_10001_10001_10001_10001_01010_00100; // V
      6'd23:   glyph = 35'b10001_10001_10001_10101_10101_10101_01010; // W
      6'd24:   glyph = 35'b10001_10001_01010_00100_01010_10001_10001; // X
      6'd25:   glyph = 35'b10001_10001_01010_00100_00100_00100_00100; // Y
      6'd26:   glyph = 35'b11111_00001_00010_00100_01000_10000_11111; // Z
      6'd27:   glyph = 35'b01110_10001_10011_10101_11001_10001_01110; // 0
      6'd28:   glyph = 35'b00100_01100_00100_00100_00100_00100_01110; // 1
      6'd29:   glyph = 35'b01110_10001_00001_00010_00100_01000_11111; // 2
      6'd30:   glyph = 35'b11111_00010_00100_00010_00001_10001_01110; // 3
      6'd31:   glyph = 35'b00010_00110_01010_10010_11111_00010_00010; // 4
      6'd32:   glyph = 35'b11111_10000_11110_00001_00001_10001_01110; // 5
      6'd33:   glyph = 35'b00110_01000_10000_11110_10001_10001_01110; // 6
      6'd34:   glyph = 35'b11111_00001_00010_00100_01000_01000_01000; // 7
      6'd35:   glyph = 35'b01110_10001_10001_01110_10001_10001_01110; // 8
      6'd36:   glyph = 35'b01110_10001_10001_01111_00001_00010_01100; // 9
      CH_BANG: glyph = 35'b00100_00100_00100_00100_00100_00000_00100; // !
      default: glyph = '0;
    endcase
  end

  always_comb begin
    bits_o = '0;
    case (row_i)
      3'd0:    bits_o = glyph[34:30];
      3'd1:    bits_o = glyph[29:25];
      3'd2:    bits_o = glyph[24:20];
      3'd3:    bits_o = glyph[19:15];
      3'd4:    bits_o = glyph[14:10];
      3'd5:    bits_o = glyph[9:5];
      3'd6:    bits_o = glyph[4:0];
      default: bits_o = '0;
    endcase
  end

endmodule

// File: rtl/ui_text_renderer.sv
// Typewriter text renderer: scans an N-character string one pixel per clock into
// x/y/colour/plot for the vga_adapter, optionally pacing characters by frame ticks.
module ui_text_renderer
  import ui_pkg::*;
#(
  parameter int         NUM_CHARS    = 5,
  parameter int         X0           = 70,
  parameter int         Y0           = 60,
  parameter int         SPACING      = 1,
  parameter logic [2:0] FG           = 3'b110,
  parameter logic [2:0] BG           = 3'b000,
  parameter int         FRAME_CYCLES = 833333,
  parameter int         CHAR_FRAMES  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [6*NUM_CHARS-1:0] text,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             dbg_state
);

  // Handshake: start is a request accepted only while busy is low (text/clear
  // sampled on that edge); plot qualifies x/y/colour for exactly one cycle.

  localparam int CHW   = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int FW    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int CFW   = (CHAR_FRAMES > 1) ? $clog2(CHAR_FRAMES) : 1;
  localparam int PITCH = GLYPH_W + SPACING;

  rstate_e                state_q;
  logic [6*NUM_CHARS-1:0] text_q;
  logic                   clear_q;
  logic [CHW-1:0]         char_q;
  logic [2:0]             row_q;
  logic [2:0]             col_q;
  logic [FW-1:0]          frame_q;
  logic [CFW-1:0]         frames_q;
  logic [7:0]             x_q;
  logic [6:0]             y_q;
  logic [2:0]             colour_q;
  logic                   plot_q;
  logic                   busy_q;
  logic                   done_q;

  logic [5:0] code;
  logic [4:0] row_bits;
  logic       pix_bit;
  logic [8:0] px;
  logic [7:0] py;
  logic       on_screen;
  logic       tick;

  always_comb begin
    code = text_q[5:0];
    for (int i = 1; i < NUM_CHARS; i++) begin
      if (char_q == CHW'(i)) code = text_q[6*i +: 6];
    end
  end

  glyph_rom_5x7 u_rom (
    .code_i (code),
    .row_i  (row_q),
    .bits_o (row_bits)
  );

  // Address is computed wider than the screen so off-screen pixels are dropped, not wrapped.
  always_comb begin
    px        = 9'(X0 + int'(char_q) * PITCH + int'(col_q));
    py        = 8'(Y0 + int'(row_q));
    on_screen = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
    pix_bit   = row_bits[3'd4 - col_q];
    tick      = (frame_q == FW'(FRAME_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      text_q   <= '0;
      clear_q  <= 1'b0;
      char_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      frame_q  <= '0;
      frames_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= BG;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      if (state_q == ST_IDLE) frame_q <= '0;
      else                    frame_q <= tick ? '0 : frame_q + 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            text_q  <= text;
            clear_q <= clear;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          char_q  <= '0;
          row_q   <= '0;
          col_q   <= '0;
          state_q <= ST_DRAW;
        end
        ST_DRAW: begin
          plot_q <= on_screen;
          if (on_screen) begin
            x_q      <= px[7:0];
            y_q      <= py[6:0];
            colour_q <= (clear_q || !pix_bit) ? BG : FG;
          end
          if (col_q == 3'(GLYPH_W - 1)) begin
            col_q <= '0;
            if (row_q == 3'(GLYPH_H - 1)) begin
              row_q   <= '0;
              state_q <= ST_NEXT;
            end else begin
              row_q <= row_q + 3'd1;
            end
          end else begin
            col_q <= col_q + 3'd1;
          end
        end
        ST_NEXT: begin
          if (char_q == CHW'(NUM_CHARS - 1)) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            char_q <= char_q + 1'b1;
            if (CHAR_FRAMES == 0) begin
              state_q <= ST_DRAW;
            end else begin
              frame_q  <= '0;
              frames_q <= '0;
              state_q  <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (tick) begin
            if (frames_q == CFW'(CHAR_FRAMES - 1)) state_q <= ST_DRAW;
            else                                   frames_q <= frames_q + 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ui_text_renderer.sv
// Directed bench for ui_text_renderer: three instances cover default placement,
// frame-paced reveal and right-screen-edge clipping.
module tb_ui_text_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        clear;
  logic [29:0] text_bus;
  logic [1:0]  sel;

  logic [7:0] x_a, x_b, x_c;
  logic [6:0] y_a, y_b, y_c;
  logic [2:0] col_a, col_b, col_c;
  logic       plot_a, plot_b, plot_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [2:0] st_a, st_b, st_c;
  logic       start_a, start_b, start_c;

  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_colour;
  logic       m_plot, m_busy, m_done;

  int checks = 0;
  int failures = 0;

  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int          obs_idx_q[$];
  int          first_idx, done_idx, busy_lo_idx, done_cnt;

  always #5 clk = ~clk;

  assign start_a = start && (sel == 2'd0);
  assign start_b = start && (sel == 2'd1);
  assign start_c = start && (sel == 2'd2);

  ui_text_renderer #(.NUM_CHARS(5), .FRAME_CYCLES(4), .CHAR_FRAMES(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .clear(clear), .text(text_bus),
    .x(x_a), .y(y_a), .colour(col_a), .plot(plot_a), .busy(busy_a), .done(done_a),
    .dbg_state(st_a)
  );

  ui_text_renderer #(.NUM_CHARS(3), .FRAME_CYCLES(4), .CHAR_FRAMES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .clear(clear), .text(text_bus[17:0]),
    .x(x_b), .y(y_b), .colour(col_b), .plot(plot_b), .busy(busy_b), .done(done_b),
    .dbg_state(st_b)
  );

  ui_text_renderer #(.NUM_CHARS(3), .X0(150), .FRAME_CYCLES(4), .CHAR_FRAMES(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .clear(clear), .text(text_bus[17:0]),
    .x(x_c), .y(y_c), .colour(col_c), .plot(plot_c), .busy(busy_c), .done(done_c),
    .dbg_state(st_c)
  );

  always_comb begin
    m_x = x_a; m_y = y_a; m_colour = col_a; m_plot = plot_a; m_busy = busy_a; m_done = done_a;
    if (sel == 2'd1) begin
      m_x = x_b; m_y = y_b; m_colour = col_b; m_plot = plot_b; m_busy = busy_b; m_done = done_b;
    end else if (sel == 2'd2) begin
      m_x = x_c; m_y = y_c; m_colour = col_c; m_plot = plot_c; m_busy = busy_c; m_done = done_c;
    end
  end

  function automatic logic [29:0] txt(input int c0, input int c1, input int c2,
                                      input int c3, input int c4);
    return {6'(c4), 6'(c3), 6'(c2), 6'(c1), 6'(c0)};
  endfunction

  // Hand-copied glyphs for the letters used in the vectors; anything else is blank.
  function automatic logic [34:0] glyph(input logic [5:0] code);
    case (code)
      6'd1:    return 35'b01110_10001_10001_11111_10001_10001_10001;
      6'd18:   return 35'b11110_10001_10001_11110_10100_10010_10001;
      6'd19:   return 35'b01111_10000_10000_01110_00001_00001_11110;
      6'd20:   return 35'b11111_00100_00100_00100_00100_00100_00100;
      6'd37:   return 35'b00100_00100_00100_00100_00100_00000_00100;
      default: return '0;
    endcase
  endfunction

  task automatic build_exp(input int x0, input int n, input logic [29:0] codes, input logic clr);
    logic [34:0] g;
    logic [4:0]  rb;
    logic [2:0]  c;
    int          xx, yy;
    exp_q.delete();
    for (int ch = 0; ch < n; ch++) begin
      g = glyph(codes[6*ch +: 6]);
      for (int r = 0; r < 7; r++) begin
        rb = g[34-5*r -: 5];
        for (int col = 0; col < 5; col++) begin
          xx = x0 + ch * 6 + col;
          yy = 60 + r;
          c  = (clr || !rb[4-col]) ? 3'b000 : 3'b110;
          if (xx <= 159 && yy <= 119) exp_q.push_back({8'(xx), 7'(yy), c});
        end
      end
    end
  endtask

  // Pulses start, then records every plotted pixel with its cycle index (1 = first
  // negedge after the accepting edge) until busy falls after done, or budget runs out.
  task automatic capture(input int budget, input int inject_at, input logic [29:0] inj_text);
    obs_q.delete(); obs_idx_q.delete();
    first_idx = -1; done_idx = -1; busy_lo_idx = -1; done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int idx = 1; idx <= budget; idx++) begin
      if (m_plot) begin
        obs_q.push_back({m_x, m_y, m_colour});
        obs_idx_q.push_back(idx);
        if (first_idx < 0) first_idx = idx;
      end
      if (m_done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = idx;
      end
      if (done_idx >= 0 && !m_busy && busy_lo_idx < 0) busy_lo_idx = idx;
      start = (idx == inject_at);
      if (idx == inject_at) text_bus = inj_text;
      if (busy_lo_idx >= 0) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int plots, busys;
    checks++;
    if ({x_a, y_a, col_a, plot_a, busy_a, done_a} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%b plot=%b busy=%b done=%b want all 0",
               x_a, y_a, col_a, plot_a, busy_a, done_a);
    end
    checks++;
    if ({st_a, st_b, st_c} !== 9'd0) begin
      failures++;
      $display("FAIL reset_states: got %0d %0d %0d want 0 0 0", st_a, st_b, st_c);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL start_during_reset: got busy=%b want 0", busy_a);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (plot_a !== 1'b1) begin
      failures++;
      $display("FAIL mid_draw_plot: got plot=%b want 1", plot_a);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({plot_a, busy_a, x_a, y_a, st_a} !== 20'd0) begin
      failures++;
      $display("FAIL abort_outputs: got plot=%b busy=%b x=%0d y=%0d st=%0d want 0",
               plot_a, busy_a, x_a, y_a, st_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
    plots = 0; busys = 0;
    repeat (60) begin
      @(negedge clk);
      if (plot_a) plots++;
      if (busy_a) busys++;
    end
    checks++;
    if (plots !== 0 || busys !== 0) begin
      failures++;
      $display("FAIL post_abort_idle: got plots=%0d busy_cycles=%0d want 0 0", plots, busys);
    end
  endtask

  task automatic test_start();
    sel = 2'd0; clear = 1'b0;
    text_bus = txt(19, 20, 1, 18, 20);
    build_exp(70, 5, text_bus, 1'b0);
    capture(400, -1, '0);
    checks++;
    if (obs_q.size() !== 175) begin
      failures++;
      $display("FAIL start_plot_count: got %0d want 175", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL start_pixel[%0d]: got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b", i,
                 obs_q[i][17:10], obs_q[i][9:3], obs_q[i][2:0],
                 exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
      end
    end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0][17:3] !== {8'd70, 7'd60} || obs_q[$][17:3] !== {8'd98, 7'd66}) begin
        failures++;
        $display("FAIL start_corners: got first=(%0d,%0d) last=(%0d,%0d) want (70,60) (98,66)",
                 obs_q[0][17:10], obs_q[0][9:3], obs_q[$][17:10], obs_q[$][9:3]);
      end
      checks++;
      if (done_idx !== obs_idx_q[$] + 1) begin
        failures++;
        $display("FAIL start_done_after_last: got done=%0d last_plot=%0d want last+1",
                 done_idx, obs_idx_q[$]);
      end
    end
    checks++;
    if (first_idx !== 3) begin
      failures++;
      $display("FAIL start_latency: got %0d want 3", first_idx);
    end
    // 35 pixels + 1 NEXT cycle per char after a 2-cycle lead-in: done seen at 36*5+2.
    checks++;
    if (done_idx !== 182 || done_cnt !== 1) begin
      failures++;
      $display("FAIL start_done: got idx=%0d pulses=%0d want 182 1", done_idx, done_cnt);
    end
    checks++;
    if (busy_lo_idx !== 183) begin
      failures++;
      $display("FAIL start_busy_drop: got %0d want 183", busy_lo_idx);
    end
  endtask

  task automatic test_clear();
    int non_bg;
    sel = 2'd0; clear = 1'b1;
    text_bus = txt(19, 20, 1, 18, 20);
    build_exp(70, 5, text_bus, 1'b1);
    capture(400, -1, '0);
    clear = 1'b0;
    checks++;
    if (obs_q.size() !== 175) begin
      failures++;
      $display("FAIL clear_plot_count: got %0d want 175", obs_q.size());
    end
    non_bg = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i][2:0] !== 3'b000) non_bg++;
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL clear_pixel[%0d]: got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b", i,
                 obs_q[i][17:10], obs_q[i][9:3], obs_q[i][2:0],
                 exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
      end
    end
    checks++;
    if (non_bg !== 0 || done_idx < 0) begin
      failures++;
      $display("FAIL clear_all_bg: got non_bg=%0d done_idx=%0d want 0 and done", non_bg, done_idx);
    end
  endtask

  task automatic test_unused_codes();
    sel = 2'd0;
    text_bus = txt(1, 40, 0, 63, 37);
    build_exp(70, 5, text_bus, 1'b0);
    capture(400, -1, '0);
    checks++;
    if (obs_q.size() !== 175 || done_cnt !== 1) begin
      failures++;
      $display("FAIL codes_count: got plots=%0d done=%0d want 175 1", obs_q.size(), done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL codes_pixel[%0d]: got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b", i,
                 obs_q[i][17:10], obs_q[i][9:3], obs_q[i][2:0],
                 exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
      end
    end
  endtask

  task automatic test_pacing();
    int gaps[$];
    int d;
    sel = 2'd1;
    text_bus = txt(19, 20, 1, 0, 0);
    build_exp(70, 3, text_bus, 1'b0);
    capture(600, -1, '0);
    checks++;
    if (obs_q.size() !== 105 || done_idx < 0) begin
      failures++;
      $display("FAIL pace_count: got plots=%0d done_idx=%0d want 105 and done", obs_q.size(), done_idx);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL pace_pixel[%0d]: got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b", i,
                 obs_q[i][17:10], obs_q[i][9:3], obs_q[i][2:0],
                 exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
      end
    end
    for (int i = 1; i < obs_idx_q.size(); i++) begin
      d = obs_idx_q[i] - obs_idx_q[i-1] - 1;
      if (d > 0) gaps.push_back(d);
    end
    checks++;
    if (gaps.size() !== 2) begin
      failures++;
      $display("FAIL pace_gap_count: got %0d want 2", gaps.size());
    end
    // 2 frames of 4 cycles between characters, one cycle of slack either way.
    foreach (gaps[i]) begin
      checks++;
      if (!(gaps[i] >= 7 && gaps[i] <= 9)) begin
        failures++;
        $display("FAIL pace_gap[%0d]: got %0d want 7..9", i, gaps[i]);
      end
    end
  endtask

  task automatic test_right_edge();
    int min_x, max_x;
    sel = 2'd2;
    text_bus = txt(19, 20, 1, 0, 0);
    build_exp(150, 3, text_bus, 1'b0);
    capture(400, -1, '0);
    checks++;
    if (obs_q.size() !== 63) begin
      failures++;
      $display("FAIL edge_plot_count: got %0d want 63", obs_q.size());
    end
    min_x = 255; max_x = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (int'(obs_q[i][17:10]) < min_x) min_x = int'(obs_q[i][17:10]);
      if (int'(obs_q[i][17:10]) > max_x) max_x = int'(obs_q[i][17:10]);
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL edge_pixel[%0d]: got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b", i,
                 obs_q[i][17:10], obs_q[i][9:3], obs_q[i][2:0],
                 exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
      end
    end
    checks++;
    if (min_x !== 150 || max_x !== 159) begin
      failures++;
      $display("FAIL edge_x_range: got %0d..%0d want 150..159", min_x, max_x);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL edge_done: got %0d pulses want 1", done_cnt);
    end
  endtask

  task automatic test_busy_start();
    int late_plots;
    sel = 2'd0;
    text_bus = txt(19, 20, 1, 18, 20);
    build_exp(70, 5, text_bus, 1'b0);
    capture(400, 10, txt(26, 26, 26, 26, 26));
    checks++;
    if (obs_q.size() !== 175 || done_cnt !== 1) begin
      failures++;
      $display("FAIL busy_count: got plots=%0d done=%0d want 175 1", obs_q.size(), done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL busy_pixel[%0d]: got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b", i,
                 obs_q[i][17:10], obs_q[i][9:3], obs_q[i][2:0],
                 exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
      end
    end
    late_plots = 0;
    repeat (20) begin
      @(negedge clk);
      if (plot_a || busy_a) late_plots++;
    end
    checks++;
    if (late_plots !== 0) begin
      failures++;
      $display("FAIL busy_no_restart: got %0d active cycles want 0", late_plots);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    clear    = 1'b0;
    text_bus = '0;
    sel      = 2'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_start();
    test_clear();
    test_unused_codes();
    test_pacing();
    test_right_edge();
    test_busy_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
